// File: rtl/ahb3lite_arbiter.sv
// +--------------------------------------------------------------------------+
// | ahb3lite_arbiter: two-master AHB-Lite arbiter/mux onto one slave port.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module ahb3lite_arbiter #(
  parameter bit PARK_MASTER = 1'b0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        m0_req,
  input  logic        m1_req,
  output logic        m0_grant,
  output logic        m1_grant,
  input  logic [31:0] m0_HADDR,
  input  logic [31:0] m0_HWDATA,
  input  logic        m0_HWRITE,
  input  logic [2:0]  m0_HBURST,
  input  logic [2:0]  m0_HSIZE,
  input  logic [1:0]  m0_HTRANS,
  input  logic [31:0] m1_HADDR,
  input  logic [31:0] m1_HWDATA,
  input  logic        m1_HWRITE,
  input  logic [2:0]  m1_HBURST,
  input  logic [2:0]  m1_HSIZE,
  input  logic [1:0]  m1_HTRANS,
  output logic [31:0] HADDR,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  output logic [2:0]  HBURST,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam logic [1:0] C_IDLE   = 2'b00;
  localparam logic [1:0] C_NONSEQ = 2'b10;
  localparam logic [1:0] C_SEQ    = 2'b11;

  localparam logic [2:0] C_SINGLE = 3'b000;
  localparam logic [2:0] C_INCR   = 3'b001;
  localparam logic [2:0] C_WRAP4  = 3'b010;
  localparam logic [2:0] C_INCR4  = 3'b011;
  localparam logic [2:0] C_WRAP8  = 3'b100;
  localparam logic [2:0] C_INCR8  = 3'b101;
  localparam logic [2:0] C_WRAP16 = 3'b110;
  localparam logic [2:0] C_INCR16 = 3'b111;

  typedef enum logic [0:0] {
    GRANT_M0 = 1'b0,
    GRANT_M1 = 1'b1
  } grant_e;

  grant_e      grant_q, grant_d;
  logic        data_sel_q, data_sel_d;
  logic [4:0]  count_q, count_d;

  logic        w_sel;
  logic [1:0]  w_htrans;
  logic [2:0]  w_hburst;
  logic        w_own_req;
  logic        w_oth_req;
  logic        w_fixed;
  logic        w_incr_drop;
  logic        w_bnd;
  logic [4:0]  w_load;

  assign w_sel    = (grant_q == GRANT_M1);
  assign m0_grant = (grant_q == GRANT_M0);
  assign m1_grant = (grant_q == GRANT_M1);

  assign w_htrans = w_sel ? m1_HTRANS : m0_HTRANS;
  assign w_hburst = w_sel ? m1_HBURST : m0_HBURST;

  assign HADDR  = w_sel ? m1_HADDR  : m0_HADDR;
  assign HWRITE = w_sel ? m1_HWRITE : m0_HWRITE;
  assign HSIZE  = w_sel ? m1_HSIZE  : m0_HSIZE;
  assign HBURST = w_hburst;
  assign HTRANS = w_htrans;

  // Write data belongs to whoever owned the previous accepted address phase.
  assign HWDATA = data_sel_q ? m1_HWDATA : m0_HWDATA;

  assign w_own_req   = w_sel ? m1_req : m0_req;
  assign w_oth_req   = w_sel ? m0_req : m1_req;
  assign w_fixed     = (w_hburst[2:1] != 2'b00);
  assign w_incr_drop = (w_hburst == C_INCR) && !w_own_req;

  always_comb begin
    w_load = 5'd0;
    case (w_hburst)
      C_WRAP4,  C_INCR4:  w_load = 5'd3;
      C_WRAP8,  C_INCR8:  w_load = 5'd7;
      C_WRAP16, C_INCR16: w_load = 5'd15;
      default:            w_load = 5'd0;
    endcase
  end

  always_comb begin
    w_bnd = 1'b0;
    case (w_htrans)
      C_IDLE:   w_bnd = 1'b1;
      C_NONSEQ: w_bnd = (w_hburst == C_SINGLE) || w_incr_drop;
      C_SEQ:    w_bnd = w_incr_drop || (w_fixed && (count_q == 5'd1));
      default:  w_bnd = 1'b0;
    endcase
  end

  always_comb begin
    grant_d    = grant_q;
    data_sel_d = data_sel_q;
    count_d    = count_q;
    if (!HREADY) begin
      // An error's first cycle abandons the burst so the following IDLE hands over.
      if (HRESP) begin
        count_d = 5'd0;
      end
    end else begin
      data_sel_d = w_sel;
      if (w_htrans == C_NONSEQ) begin
        count_d = w_load;
      end else if ((w_htrans == C_SEQ) && (count_q != 5'd0)) begin
        count_d = count_q - 5'd1;
      end
      if (w_bnd && w_oth_req) begin
        grant_d = w_sel ? GRANT_M0 : GRANT_M1;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_q    <= grant_e'(PARK_MASTER);
      data_sel_q <= PARK_MASTER;
      count_q    <= 5'd0;
    end else begin
      grant_q    <= grant_d;
      data_sel_q <= data_sel_d;
      count_q    <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ahb3lite_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_ahb3lite_arbiter: directed scoreboard bench for ahb3lite_arbiter.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ahb3lite_arbiter;

  localparam logic [1:0] C_IDLE   = 2'b00;
  localparam logic [1:0] C_NONSEQ = 2'b10;
  localparam logic [1:0] C_SEQ    = 2'b11;
  localparam logic [2:0] C_SINGLE = 3'b000;
  localparam logic [2:0] C_WRAP4  = 3'b010;
  localparam logic [2:0] C_INCR4  = 3'b011;
  localparam logic [2:0] C_INCR8  = 3'b101;

  // mask bits: [0] grant, [1] HADDR, [2] HTRANS, [3] HWDATA
  typedef struct packed {
    logic [3:0]  m;
    logic        g;
    logic [31:0] a;
    logic [1:0]  t;
    logic [31:0] d;
  } exp_t;

  logic        HCLK;
  logic        HRESETn;
  logic        m0_req, m1_req;
  logic        m0_grant, m1_grant;
  logic [31:0] m0_HADDR, m0_HWDATA, m1_HADDR, m1_HWDATA;
  logic        m0_HWRITE, m1_HWRITE;
  logic [2:0]  m0_HBURST, m0_HSIZE, m1_HBURST, m1_HSIZE;
  logic [1:0]  m0_HTRANS, m1_HTRANS;
  logic [31:0] HADDR, HWDATA;
  logic        HWRITE;
  logic [2:0]  HBURST, HSIZE;
  logic [1:0]  HTRANS;
  logic        HREADY, HRESP;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  e;
  string nm;
  int    tests;
  int    fails;

  ahb3lite_arbiter #(.PARK_MASTER(1'b0)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m0_req(m0_req), .m1_req(m1_req),
    .m0_grant(m0_grant), .m1_grant(m1_grant),
    .m0_HADDR(m0_HADDR), .m0_HWDATA(m0_HWDATA), .m0_HWRITE(m0_HWRITE),
    .m0_HBURST(m0_HBURST), .m0_HSIZE(m0_HSIZE), .m0_HTRANS(m0_HTRANS),
    .m1_HADDR(m1_HADDR), .m1_HWDATA(m1_HWDATA), .m1_HWRITE(m1_HWRITE),
    .m1_HBURST(m1_HBURST), .m1_HSIZE(m1_HSIZE), .m1_HTRANS(m1_HTRANS),
    .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE),
    .HBURST(HBURST), .HSIZE(HSIZE), .HTRANS(HTRANS),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Outputs settle after inputs change at posedge+1; compare at the falling edge.
  always @(negedge HCLK) begin
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (e.m[0]) begin
        tests++;
        if ({m1_grant, m0_grant} !== {e.g, ~e.g}) begin
          fails++;
          $display("FAIL %s grant: got m0=%0b m1=%0b, want m1_grant=%0b only", nm, m0_grant, m1_grant, e.g);
        end
      end
      if (e.m[1]) begin
        tests++;
        if (HADDR !== e.a) begin
          fails++;
          $display("FAIL %s HADDR: got %h, want %h", nm, HADDR, e.a);
        end
      end
      if (e.m[2]) begin
        tests++;
        if (HTRANS !== e.t) begin
          fails++;
          $display("FAIL %s HTRANS: got %b, want %b", nm, HTRANS, e.t);
        end
      end
      if (e.m[3]) begin
        tests++;
        if (HWDATA !== e.d) begin
          fails++;
          $display("FAIL %s HWDATA: got %h, want %h", nm, HWDATA, e.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drv(input bit n, input logic [1:0] t, input logic [2:0] b, input logic [31:0] a);
    if (n) begin
      m1_HTRANS = t; m1_HBURST = b; m1_HADDR = a; m1_HWRITE = 1'b1;
    end else begin
      m0_HTRANS = t; m0_HBURST = b; m0_HADDR = a; m0_HWRITE = 1'b1;
    end
  endtask

  task automatic push(input string n, input logic [3:0] m, input bit g,
                      input logic [31:0] a, input logic [1:0] t, input logic [31:0] d);
    exp_t x;
    x.m = m; x.g = g; x.a = a; x.t = t; x.d = d;
    exp_q.push_back(x);
    name_q.push_back(n);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    HRESETn = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0;
    m0_HSIZE = 3'b010; m1_HSIZE = 3'b010;
    drv(0, C_IDLE, C_SINGLE, 32'h0);
    drv(1, C_NONSEQ, C_SINGLE, 32'hDEAD_0000);
    m0_HWDATA = 32'h1111_0000; m1_HWDATA = 32'h2222_0000;

    tick();
    push("reset", 4'b1111, 1'b0, 32'h0, C_IDLE, 32'h1111_0000);
    for (int i = 0; i < 10; i++) begin
      tick();
      HRESETn = 1'b1;
      push("park", 4'b0101, 1'b0, 32'h0, C_IDLE, 32'h0);
    end

    // m1 request while m0 idle, then a single write
    tick(); m1_req = 1'b1;
    push("req_pre", 4'b0001, 1'b0, 32'h0, C_IDLE, 32'h0);
    tick(); drv(1, C_NONSEQ, C_SINGLE, 32'h100); m1_req = 1'b0;
    push("m1_addr", 4'b1111, 1'b1, 32'h100, C_NONSEQ, 32'h1111_0000);
    tick(); drv(1, C_IDLE, C_SINGLE, 32'h104); m1_HWDATA = 32'hCAFE_0001; m0_req = 1'b1;
    push("m1_data", 4'b1001, 1'b1, 32'h0, C_IDLE, 32'hCAFE_0001);

    // m0 INCR4, m1 requests at beat 2
    tick(); drv(0, C_NONSEQ, C_INCR4, 32'h200);
    push("inc4_b1", 4'b1111, 1'b0, 32'h200, C_NONSEQ, 32'hCAFE_0001);
    for (int k = 1; k < 4; k++) begin
      tick(); drv(0, C_SEQ, C_INCR4, 32'(32'h200 + 4 * k)); m0_HWDATA = 32'(32'hA0 + k - 1);
      m1_req = 1'b1;
      push("inc4_beat", 4'b1011, 1'b0, 32'(32'h200 + 4 * k), C_SEQ, 32'(32'hA0 + k - 1));
    end
    tick(); m0_HWDATA = 32'hA3;
    drv(1, C_NONSEQ, C_SINGLE, 32'h300); drv(0, C_NONSEQ, C_SINGLE, 32'h400);
    m0_req = 1'b1; m1_req = 1'b1; m1_HWDATA = 32'h2222_0001;
    push("handover", 4'b1111, 1'b1, 32'h300, C_NONSEQ, 32'hA3);

    // both requesting with SINGLE transfers: strict alternation
    for (int i = 0; i < 4; i++) begin
      tick(); m0_HWDATA = 32'h0D0; m1_HWDATA = 32'h1D1;
      push("round_robin", 4'b1111, bit'(i % 2), (i % 2 == 1) ? 32'h300 : 32'h400, C_NONSEQ,
           (i % 2 == 1) ? 32'h0D0 : 32'h1D1);
    end

    // m0 INCR8 with three wait states after beat 3
    tick(); drv(0, C_NONSEQ, C_INCR8, 32'h500); drv(1, C_IDLE, C_SINGLE, 32'h300); m1_req = 1'b0;
    push("inc8_b1", 4'b1111, 1'b0, 32'h500, C_NONSEQ, 32'h1D1);
    tick(); drv(0, C_SEQ, C_INCR8, 32'h504); m0_HWDATA = 32'hB0;
    push("inc8_b2", 4'b1011, 1'b0, 32'h504, C_SEQ, 32'hB0);
    tick(); drv(0, C_SEQ, C_INCR8, 32'h508); m0_HWDATA = 32'hB1;
    push("inc8_b3", 4'b1011, 1'b0, 32'h508, C_SEQ, 32'hB1);
    for (int i = 0; i < 3; i++) begin
      tick(); HREADY = 1'b0; drv(0, C_SEQ, C_INCR8, 32'h50C); m0_HWDATA = 32'hB2; m1_req = 1'b1;
      push("wait_state", 4'b1011, 1'b0, 32'h50C, C_SEQ, 32'hB2);
    end
    for (int k = 0; k < 5; k++) begin
      tick(); HREADY = 1'b1; drv(0, C_SEQ, C_INCR8, 32'(32'h50C + 4 * k)); m0_HWDATA = 32'(32'hB2 + k);
      push("inc8_tail", 4'b1011, 1'b0, 32'(32'h50C + 4 * k), C_SEQ, 32'(32'hB2 + k));
    end

    // m1 WRAP4 with an ERROR response on beat 2
    tick(); m0_HWDATA = 32'hB7; drv(1, C_NONSEQ, C_WRAP4, 32'h600); drv(0, C_IDLE, C_SINGLE, 32'h0);
    m0_req = 1'b1; m1_req = 1'b1;
    push("inc8_end", 4'b1111, 1'b1, 32'h600, C_NONSEQ, 32'hB7);
    tick(); drv(1, C_SEQ, C_WRAP4, 32'h604); m1_HWDATA = 32'hC0;
    push("wrap_b2", 4'b1011, 1'b1, 32'h604, C_SEQ, 32'hC0);
    tick(); drv(1, C_SEQ, C_WRAP4, 32'h608); HREADY = 1'b0; HRESP = 1'b1; m1_HWDATA = 32'hC1;
    push("err_first", 4'b0111, 1'b1, 32'h608, C_SEQ, 32'h0);
    tick(); HREADY = 1'b1; HRESP = 1'b1; drv(1, C_IDLE, C_WRAP4, 32'h608);
    push("err_idle", 4'b0101, 1'b1, 32'h0, C_IDLE, 32'h0);
    tick(); HRESP = 1'b0; m0_req = 1'b0; m1_req = 1'b1; drv(1, C_NONSEQ, C_INCR4, 32'h700);
    push("err_rearb", 4'b0001, 1'b0, 32'h0, C_IDLE, 32'h0);

    // reset in the middle of an m1 burst
    tick(); drv(1, C_NONSEQ, C_INCR4, 32'h700);
    push("m1_inc4", 4'b0011, 1'b1, 32'h700, C_NONSEQ, 32'h0);
    tick(); drv(1, C_SEQ, C_INCR4, 32'h704);
    push("m1_inc4_b2", 4'b0001, 1'b1, 32'h0, C_SEQ, 32'h0);
    tick(); drv(1, C_SEQ, C_INCR4, 32'h708);
    m0_HADDR = 32'h0AA0; m0_HWDATA = 32'h0DD0; m0_HTRANS = C_IDLE;
    HRESETn = 1'b0;
    push("async_rst", 4'b1111, 1'b0, 32'h0AA0, C_IDLE, 32'h0DD0);
    tick(); HRESETn = 1'b1;
    push("post_rst", 4'b0001, 1'b0, 32'h0, C_IDLE, 32'h0);
    tick(); drv(1, C_IDLE, C_SINGLE, 32'h0); m1_req = 1'b0;
    push("post_rst_arb", 4'b0001, 1'b1, 32'h0, C_IDLE, 32'h0);

    tick();
    tick();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
